// File: rtl/polarity_restore_rx.sv
// polarity_restore_rx: hunts a sync word on a serial line, detects line inversion
// and presents the following polarity-restored data word in parallel.
module polarity_restore_rx #(
  parameter int                SYNC_W = 8,
  parameter logic [SYNC_W-1:0] SYNC   = 8'hD5,
  parameter int                DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              xin_i,
  input  logic              bit_en_i,
  output logic [DATA_W-1:0] yout_o,
  output logic              yvalid_o,
  output logic              inverted_o,
  output logic              locked_o
);
  localparam int HW = $clog2(SYNC_W + 1);
  localparam int DW = $clog2(DATA_W + 1);
  typedef enum logic {HUNT, DATA} state_t;
  state_t            state_q;
  logic              s1_q, s2_q;
  logic [SYNC_W-1:0] sr_q, sr_d;
  logic [HW-1:0]     hcnt_q;
  logic [DATA_W-1:0] dsr_q, dsr_d, yout_q;
  logic [DW-1:0]     dcnt_q;
  logic              yvalid_q, inv_q;
  logic              full, last;
  assign sr_d       = {sr_q[SYNC_W-2:0], s2_q};
  assign dsr_d      = {dsr_q[DATA_W-2:0], s2_q ^ inv_q};
  // only windows made entirely of bits seen since entering HUNT may match
  assign full       = hcnt_q >= HW'(SYNC_W - 1);
  assign last       = dcnt_q == DW'(DATA_W - 1);
  assign yout_o     = yout_q;
  assign yvalid_o   = yvalid_q;
  assign inverted_o = inv_q;
  assign locked_o   = state_q == DATA;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      sr_q     <= '0;
      hcnt_q   <= '0;
      dsr_q    <= '0;
      dcnt_q   <= '0;
      yout_q   <= '0;
      yvalid_q <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      s1_q     <= xin_i;
      s2_q     <= s1_q;
      yvalid_q <= 1'b0;
      if (bit_en_i) begin
        if (state_q == HUNT) begin
          sr_q <= sr_d;
          if (hcnt_q != HW'(SYNC_W)) hcnt_q <= hcnt_q + HW'(1);
          if (full && (sr_d == SYNC || sr_d == ~SYNC)) begin
            inv_q   <= sr_d != SYNC;
            state_q <= DATA;
            hcnt_q  <= '0;
            dcnt_q  <= '0;
          end
        end else begin
          dsr_q  <= dsr_d;
          dcnt_q <= dcnt_q + DW'(1);
          if (last) begin
            yout_q   <= dsr_d;
            yvalid_q <= 1'b1;
            state_q  <= HUNT;
            hcnt_q   <= '0;
            dcnt_q   <= '0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_polarity_restore_rx.sv
// tb_polarity_restore_rx: frame table, corner sequences and randomized bursts
// compared against a queue-based receiver model.
module tb_polarity_restore_rx;
  logic       clk = 0, rst_n = 0, xin = 0, bit_en = 0;
  logic [7:0] yout;
  logic       yvalid, inverted, locked;
  int         vectors = 0, errors = 0;
  always #5 clk = ~clk;
  polarity_restore_rx dut (
    .clk(clk), .rst_n(rst_n), .xin_i(xin), .bit_en_i(bit_en),
    .yout_o(yout), .yvalid_o(yvalid), .inverted_o(inverted), .locked_o(locked)
  );
  bit         hq[$];
  bit         dq[$];
  logic       m_lock, m_inv, m_val;
  logic [7:0] m_y;
  task automatic m_reset();
    hq.delete(); dq.delete();
    m_lock = 0; m_inv = 0; m_val = 0; m_y = 0;
  endtask
  // model: last 8 hunt bits as a number; data bits collected until 8 arrive
  task automatic m_bit(input bit b);
    int w;
    m_val = 0;
    if (!m_lock) begin
      hq.push_back(b);
      if (hq.size() >= 8) begin
        w = 0;
        for (int i = hq.size() - 8; i < hq.size(); i++) w = w * 2 + int'(hq[i]);
        if (w == 'hD5 || w == 'h2A) begin
          m_lock = 1; m_inv = (w == 'h2A); hq.delete();
        end
      end
    end else begin
      dq.push_back(b ^ m_inv);
      if (dq.size() == 8) begin
        w = 0;
        foreach (dq[i]) w = w * 2 + int'(dq[i]);
        m_y = 8'(w); m_val = 1; m_lock = 0; dq.delete();
      end
    end
  endtask
  task automatic check(input string nm);
    vectors++;
    if ({yout, yvalid, inverted, locked} !== {m_y, m_val, m_inv, m_lock}) begin
      errors++;
      $display("FAIL %s: got yout=%h yvalid=%b inv=%b lock=%b, want yout=%h yvalid=%b inv=%b lock=%b",
               nm, yout, yvalid, inverted, locked, m_y, m_val, m_inv, m_lock);
    end
  endtask
  task automatic expect_out(input string nm, input logic [7:0] y, input logic v, input logic inv, input logic lk);
    vectors++;
    if ({yout, yvalid, inverted, locked} !== {y, v, inv, lk}) begin
      errors++;
      $display("FAIL %s: got yout=%h yvalid=%b inv=%b lock=%b, want yout=%h yvalid=%b inv=%b lock=%b",
               nm, yout, yvalid, inverted, locked, y, v, inv, lk);
    end
  endtask
  task automatic send_bit(input bit b, input string nm);
    xin = b;
    repeat (3) begin
      @(posedge clk); #1;
      m_val = 0;
      check({nm, "/gap"});
    end
    bit_en = 1;
    @(posedge clk); #1;
    bit_en = 0;
    m_bit(b);
    check({nm, "/bit"});
  endtask
  task automatic send_byte(input logic [7:0] v, input string nm);
    for (int i = 7; i >= 0; i--) send_bit(v[i], nm);
  endtask
  typedef struct {
    logic [7:0] sync_b;
    logic [7:0] data_b;
    logic [7:0] exp_y;
    logic       exp_inv;
  } frame_t;
  frame_t tbl[5];
  int     n_cyc;
  bit     st[$];
  bit     en[];
  bit     xv[];
  initial begin
    tbl = '{'{8'hD5, 8'h3C, 8'h3C, 1'b0}, '{8'h2A, 8'hC3, 8'h3C, 1'b1},
            '{8'hD5, 8'hA5, 8'hA5, 1'b0}, '{8'h2A, 8'h0F, 8'hF0, 1'b1},
            '{8'hD5, 8'hD5, 8'hD5, 1'b0}};
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset_hold", 8'h00, 0, 0, 0);
    rst_n = 1;
    repeat (6) begin
      @(posedge clk); #1;
      expect_out("idle_no_bit_en", 8'h00, 0, 0, 0);
    end
    foreach (tbl[i]) begin
      send_byte(tbl[i].sync_b, "frame_sync");
      expect_out("lock_after_sync", 8'(i == 0 ? 8'h00 : tbl[i-1].exp_y), 0,
                 tbl[i].exp_inv, 1);
      send_byte(tbl[i].data_b, "frame_data");
      expect_out("frame_out", tbl[i].exp_y, 1, tbl[i].exp_inv, 0);
    end
    send_byte(8'hD4, "near_miss");
    expect_out("near_miss_nolock", 8'hD5, 0, 0, 0);
    send_byte(8'hD5, "slide_sync");
    expect_out("slide_lock", 8'hD5, 0, 0, 1);
    send_byte(8'h81, "slide_data");
    expect_out("slide_out", 8'h81, 1, 0, 0);
    send_byte(8'hD5, "abort_sync");
    for (int i = 7; i >= 4; i--) send_bit(1'(8'h7E >> i), "abort_data");
    rst_n = 0;
    #1;
    m_reset();
    expect_out("abort_async_clear", 8'h00, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1;
    check("abort_held");
    send_byte(8'hD5, "after_abort_sync");
    send_byte(8'h7E, "after_abort_data");
    expect_out("after_abort_out", 8'h7E, 1, 0, 0);
    // randomized frames with noise, irregular Bit_en including back-to-back cycles
    for (int f = 0; f < 40; f++) begin
      int n;
      logic [7:0] s, d;
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) st.push_back(1'($urandom_range(0, 1)));
      s = $urandom_range(0, 1) ? 8'hD5 : 8'h2A;
      d = 8'($urandom);
      for (int i = 7; i >= 0; i--) st.push_back(s[i]);
      for (int i = 7; i >= 0; i--) st.push_back(d[i]);
    end
    n_cyc = 2 * st.size() + 20;
    en = new[n_cyc];
    xv = new[n_cyc];
    begin
      int idx = 0;
      for (int k = 0; k < n_cyc; k++) begin
        xv[k] = 1'($urandom_range(0, 1));
        en[k] = 0;
      end
      for (int k = 2; k < n_cyc; k++)
        if (idx < st.size() && $urandom_range(0, 3) != 0) begin
          en[k] = 1;
          xv[k-2] = st[idx++];
        end
    end
    for (int k = 0; k < n_cyc; k++) begin
      xin = xv[k];
      bit_en = en[k];
      @(posedge clk); #1;
      if (en[k]) m_bit(xv[k-2]);
      else m_val = 0;
      check("random");
    end
    bit_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
